stream_arbiter: RTL and testbench

Parametrised N-channel merger for 32-bit stb/ack streams. It generalises the fixed two-input rs232_tx merge at the top level to any channel count, with selectable round-robin or fixed-priority arbitration. Optional message locking keeps a grant on one channel until that channel sends a terminator word, so text lines from different processes never interleave. A sticky exception flags handshake violations; the top level ORs it into the global exception like every process.

---
 rtl/stream_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_stream_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// stream_arbiter
//
// Merges CHANNELS independent stb/ack word streams into a single stb/ack
// output stream. Arbitration is round-robin (MODE=0) or fixed priority with
// the lowest index winning (MODE=1). With LOCK=1 a grant is held on one
// channel until that channel sends the TERMINATOR word, so multi-word
// messages from different sources never interleave. An optional TIMEOUT
// releases a lock held by a silent channel. A sticky exception flags a
// producer that withdraws stb while it is being acknowledged.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst             synchronous, active-low reset
//   input_in        packed channel data, channel k at [k*WIDTH +: WIDTH]
//   input_in_stb    per-channel word valid
//   input_in_ack    per-channel word accepted (at most one bit high)
//   output_out      merged data word
//   output_out_stb  merged word valid
//   output_out_ack  consumer accepted the merged word
//   output_channel  index of the channel that sourced output_out
//   exception       sticky protocol-violation flag, cleared only by reset

module stream_arbiter #(
  parameter int              WIDTH      = 32,
  parameter int              CHANNELS   = 2,
  parameter int              MODE       = 0,
  parameter int              LOCK       = 1,
  parameter logic [WIDTH-1:0] TERMINATOR = 10,
  parameter int              TIMEOUT    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   input_in,
  input  logic [CHANNELS-1:0]         input_in_stb,
  output logic [CHANNELS-1:0]         input_in_ack,
  output logic [WIDTH-1:0]            output_out,
  output logic                        output_out_stb,
  input  logic                        output_out_ack,
  output logic [$clog2(CHANNELS)-1:0] output_channel,
  output logic                        exception
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CHANNELS-1:0] ONE_HOT = {{(CHANNELS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ARB,
    ACK_IN,
    SEND,
    LOCKED
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CH_W-1:0]     last_grant;
  logic [CH_W-1:0]     last_grant_next;
  logic [CH_W-1:0]     channel_next;
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    wait_cnt_next;
  logic [CHANNELS-1:0] ack_next;
  logic [WIDTH-1:0]    out_next;
  logic                out_stb_next;
  logic                exception_next;

  logic [CH_W-1:0]     pick;
  logic                found;
  int                  rr_idx;

  // Grant selection for the ARB state. Round-robin starts its search one
  // past the channel that last completed a word, wrapping at CHANNELS, and
  // takes the first asserted stb. Fixed priority walks downward so the
  // final assignment left standing is the lowest asserted index.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    rr_idx = 0;
    if (MODE == 1) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (input_in_stb[i]) begin
          pick = CH_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        rr_idx = (int'(last_grant) + 1 + i) % CHANNELS;
        if (!found && input_in_stb[rr_idx]) begin
          pick  = CH_W'(rr_idx);
          found = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each output register takes at the next edge.
  // The input ack is raised on the transition into ACK_IN, which makes it
  // visible for exactly the ACK_IN cycle. The wait counter only advances
  // while LOCKED and is zeroed whenever LOCKED is entered or left.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    channel_next    = output_channel;
    wait_cnt_next   = wait_cnt;
    ack_next        = '0;
    out_next        = output_out;
    out_stb_next    = output_out_stb;
    exception_next  = exception;

    case (state)
      ARB: begin
        if (|input_in_stb) begin
          channel_next = pick;
          ack_next     = ONE_HOT << pick;
          state_next   = ACK_IN;
        end
      end

      ACK_IN: begin
        if (input_in_stb[output_channel]) begin
          out_next     = input_in[int'(output_channel)*WIDTH +: WIDTH];
          out_stb_next = 1'b1;
          state_next   = SEND;
        end else begin
          exception_next = 1'b1;
          state_next     = ARB;
        end
      end

      SEND: begin
        if (output_out_ack) begin
          out_stb_next    = 1'b0;
          last_grant_next = output_channel;
          wait_cnt_next   = '0;
          if (LOCK != 0 && output_out != TERMINATOR) begin
            state_next = LOCKED;
          end else begin
            state_next = ARB;
          end
        end
      end

      LOCKED: begin
        if (input_in_stb[output_channel]) begin
          ack_next      = ONE_HOT << output_channel;
          wait_cnt_next = '0;
          state_next    = ACK_IN;
        end else if (TIMEOUT > 0 && wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          wait_cnt_next = '0;
          state_next    = ARB;
        end else if (TIMEOUT > 0) begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = ARB;
      end
    endcase
  end

  // State and output registers. Reset drops any word held in SEND and
  // clears the ack register, so no stale ack pulse can follow a reset.
  // last_grant resets to the top channel so round-robin begins at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ARB;
      last_grant     <= CH_W'(CHANNELS - 1);
      output_channel <= '0;
      wait_cnt       <= '0;
      input_in_ack   <= '0;
      output_out     <= '0;
      output_out_stb <= 1'b0;
      exception      <= 1'b0;
    end else begin
      state          <= state_next;
      last_grant     <= last_grant_next;
      output_channel <= channel_next;
      wait_cnt       <= wait_cnt_next;
      input_in_ack   <= ack_next;
      output_out     <= out_next;
      output_out_stb <= out_stb_next;
      exception      <= exception_next;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter
//
// Directed bench for stream_arbiter using three instances:
//   dut_a: CHANNELS=4, round-robin, unlocked  (single word, fairness, violation)
//   dut_b: CHANNELS=4, fixed priority, unlocked
//   dut_c: CHANNELS=2, round-robin, locked, TIMEOUT=8
// Inputs change 1 time unit after a rising edge and outputs are sampled
// at that same point, so every value seen reflects the edge just passed.

module tb_stream_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [127:0] a_in;
  logic [3:0]   a_stb;
  logic [3:0]   a_ack;
  logic [31:0]  a_out;
  logic         a_ostb;
  logic         a_oack;
  logic [1:0]   a_ch;
  logic         a_exc;

  logic [127:0] b_in;
  logic [3:0]   b_stb;
  logic [3:0]   b_ack;
  logic [31:0]  b_out;
  logic         b_ostb;
  logic         b_oack;
  logic [1:0]   b_ch;
  logic         b_exc;

  logic [63:0]  c_in;
  logic [1:0]   c_stb;
  logic [1:0]   c_ack;
  logic [31:0]  c_out;
  logic         c_ostb;
  logic         c_oack;
  logic [0:0]   c_ch;
  logic         c_exc;

  int checks = 0;
  int errors = 0;

  stream_arbiter #(
    .WIDTH(32), .CHANNELS(4), .MODE(0), .LOCK(0), .TERMINATOR(32'd10), .TIMEOUT(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .input_in(a_in), .input_in_stb(a_stb), .input_in_ack(a_ack),
    .output_out(a_out), .output_out_stb(a_ostb), .output_out_ack(a_oack),
    .output_channel(a_ch), .exception(a_exc)
  );

  stream_arbiter #(
    .WIDTH(32), .CHANNELS(4), .MODE(1), .LOCK(0), .TERMINATOR(32'd10), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .input_in(b_in), .input_in_stb(b_stb), .input_in_ack(b_ack),
    .output_out(b_out), .output_out_stb(b_ostb), .output_out_ack(b_oack),
    .output_channel(b_ch), .exception(b_exc)
  );

  stream_arbiter #(
    .WIDTH(32), .CHANNELS(2), .MODE(0), .LOCK(1), .TERMINATOR(32'd10), .TIMEOUT(8)
  ) dut_c (
    .clk(clk), .rst(rst),
    .input_in(c_in), .input_in_stb(c_stb), .input_in_ack(c_ack),
    .output_out(c_out), .output_out_stb(c_ostb), .output_out_ack(c_oack),
    .output_channel(c_ch), .exception(c_exc)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle every input, then hold reset low across two edges.
  task automatic do_reset();
    a_stb = '0; a_oack = 1'b0; a_in = '0;
    b_stb = '0; b_oack = 1'b0; b_in = '0;
    c_stb = '0; c_oack = 1'b0; c_in = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    checks++; if (a_ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected %b", a_ack, 4'b0000); end
    checks++; if (a_ostb !== 1'b0) begin errors++; $display("[TB] FAIL reset_ostb: got %b expected 0", a_ostb); end
    checks++; if (a_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected 0", a_out); end
    checks++; if (a_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_channel: got %0d expected 0", a_ch); end
    checks++; if (a_exc !== 1'b0) begin errors++; $display("[TB] FAIL reset_exception: got %b expected 0", a_exc); end
    checks++; if ({b_ack, b_ostb, b_exc} !== 6'b0) begin errors++; $display("[TB] FAIL reset_b: got %b expected 0", {b_ack, b_ostb, b_exc}); end
    checks++; if ({c_ack, c_ostb, c_exc} !== 4'b0) begin errors++; $display("[TB] FAIL reset_c: got %b expected 0", {c_ack, c_ostb, c_exc}); end
  endtask

  task automatic test_single_word();
    $display("[TB] test_single_word");
    do_reset();
    a_oack = 1'b1;
    a_in[1*32 +: 32] = 32'h41;
    a_stb = 4'b0010;
    tick();
    checks++; if (a_ack !== 4'b0010) begin errors++; $display("[TB] FAIL single_ack: got %b expected %b", a_ack, 4'b0010); end
    checks++; if (a_ostb !== 1'b0) begin errors++; $display("[TB] FAIL single_early_stb: got %b expected 0", a_ostb); end
    tick();
    a_stb = 4'b0000;
    checks++; if (a_ostb !== 1'b1) begin errors++; $display("[TB] FAIL single_stb: got %b expected 1", a_ostb); end
    checks++; if (a_out !== 32'h41) begin errors++; $display("[TB] FAIL single_out: got %h expected %h", a_out, 32'h41); end
    checks++; if (a_ch !== 2'd1) begin errors++; $display("[TB] FAIL single_channel: got %0d expected 1", a_ch); end
    checks++; if (a_ack !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_drop: got %b expected 0", a_ack); end
    tick();
    checks++; if (a_ostb !== 1'b0) begin errors++; $display("[TB] FAIL single_stb_drop: got %b expected 0", a_ostb); end
  endtask

  task automatic test_round_robin();
    int e;
    $display("[TB] test_round_robin");
    do_reset();
    a_oack = 1'b1;
    for (int k = 0; k < 4; k++) a_in[k*32 +: 32] = 32'h100 + k;
    a_stb = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      e = j % 4;
      tick();
      checks++; if (a_ack !== (4'b0001 << e)) begin errors++; $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", j, a_ack, 4'b0001 << e); end
      tick();
      checks++; if (a_ostb !== 1'b1 || a_out !== 32'h100 + e || a_ch !== 2'(e)) begin errors++; $display("[TB] FAIL rr_word[%0d]: got stb=%b data=%h ch=%0d expected stb=1 data=%h ch=%0d", j, a_ostb, a_out, a_ch, 32'h100 + e, e); end
      tick();
      checks++; if (a_ostb !== 1'b0) begin errors++; $display("[TB] FAIL rr_gap[%0d]: got %b expected 0", j, a_ostb); end
    end
  endtask

  task automatic test_fixed_priority();
    $display("[TB] test_fixed_priority");
    do_reset();
    b_oack = 1'b1;
    b_in[0*32 +: 32] = 32'h30;
    b_in[2*32 +: 32] = 32'h32;
    b_stb = 4'b0101;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (b_ack !== 4'b0001) begin errors++; $display("[TB] FAIL fp_ack[%0d]: got %b expected %b", j, b_ack, 4'b0001); end
      tick();
      checks++; if (b_ostb !== 1'b1 || b_out !== 32'h30 || b_ch !== 2'd0) begin errors++; $display("[TB] FAIL fp_word[%0d]: got stb=%b data=%h ch=%0d expected stb=1 data=30 ch=0", j, b_ostb, b_out, b_ch); end
      if (j == 2) b_stb = 4'b0100;
      tick();
    end
    tick();
    checks++; if (b_ack !== 4'b0100) begin errors++; $display("[TB] FAIL fp_switch_ack: got %b expected %b", b_ack, 4'b0100); end
    tick();
    checks++; if (b_ostb !== 1'b1 || b_out !== 32'h32 || b_ch !== 2'd2) begin errors++; $display("[TB] FAIL fp_switch_word: got stb=%b data=%h ch=%0d expected stb=1 data=32 ch=2", b_ostb, b_out, b_ch); end
  endtask

  task automatic test_message_lock();
    logic [31:0] msg [3];
    msg[0] = 32'h41;
    msg[1] = 32'h42;
    msg[2] = 32'h0A;
    $display("[TB] test_message_lock");
    do_reset();
    c_oack = 1'b1;
    c_in[31:0]  = msg[0];
    c_in[63:32] = 32'h5A;
    c_stb = 2'b11;
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++; if (c_ack !== 2'b01) begin errors++; $display("[TB] FAIL lock_ack[%0d]: got %b expected 01", w, c_ack); end
      tick();
      checks++; if (c_ostb !== 1'b1 || c_out !== msg[w] || c_ch !== 1'b0) begin errors++; $display("[TB] FAIL lock_word[%0d]: got stb=%b data=%h ch=%0d expected stb=1 data=%h ch=0", w, c_ostb, c_out, c_ch, msg[w]); end
      if (w < 2) c_in[31:0] = msg[w + 1];
      else c_stb = 2'b10;
      tick();
      checks++; if (c_ack !== 2'b00 || c_ostb !== 1'b0) begin errors++; $display("[TB] FAIL lock_gap[%0d]: got ack=%b stb=%b expected ack=00 stb=0", w, c_ack, c_ostb); end
    end
    tick();
    checks++; if (c_ack !== 2'b10) begin errors++; $display("[TB] FAIL lock_release_ack: got %b expected 10", c_ack); end
    tick();
    checks++; if (c_ostb !== 1'b1 || c_out !== 32'h5A || c_ch !== 1'b1) begin errors++; $display("[TB] FAIL lock_release_word: got stb=%b data=%h ch=%0d expected stb=1 data=5a ch=1", c_ostb, c_out, c_ch); end
  endtask

  task automatic test_lock_timeout();
    $display("[TB] test_lock_timeout");
    do_reset();
    c_oack = 1'b1;
    c_in[31:0]  = 32'h41;
    c_in[63:32] = 32'h5A;
    c_stb = 2'b11;
    tick();
    checks++; if (c_ack !== 2'b01) begin errors++; $display("[TB] FAIL timeout_first_ack: got %b expected 01", c_ack); end
    tick();
    checks++; if (c_out !== 32'h41 || c_ostb !== 1'b1) begin errors++; $display("[TB] FAIL timeout_first_word: got stb=%b data=%h expected stb=1 data=41", c_ostb, c_out); end
    c_stb = 2'b10;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (c_ack !== 2'b00) begin errors++; $display("[TB] FAIL timeout_hold[%0d]: got %b expected 00", i, c_ack); end
    end
    tick();
    checks++; if (c_ack !== 2'b10) begin errors++; $display("[TB] FAIL timeout_release_ack: got %b expected 10", c_ack); end
    tick();
    checks++; if (c_out !== 32'h5A || c_ch !== 1'b1 || c_ostb !== 1'b1) begin errors++; $display("[TB] FAIL timeout_release_word: got stb=%b data=%h ch=%0d expected stb=1 data=5a ch=1", c_ostb, c_out, c_ch); end
    checks++; if (c_exc !== 1'b0) begin errors++; $display("[TB] FAIL timeout_exception: got %b expected 0", c_exc); end
  endtask

  task automatic test_violation_reset();
    $display("[TB] test_violation_reset");
    do_reset();
    a_oack = 1'b0;
    a_in[0*32 +: 32] = 32'h77;
    a_in[3*32 +: 32] = 32'h33;
    a_stb = 4'b0001;
    tick();
    checks++; if (a_ack !== 4'b0001) begin errors++; $display("[TB] FAIL viol_ack: got %b expected 0001", a_ack); end
    a_stb = 4'b0000;
    tick();
    checks++; if (a_exc !== 1'b1 || a_ostb !== 1'b0) begin errors++; $display("[TB] FAIL viol_flag: got exc=%b stb=%b expected exc=1 stb=0", a_exc, a_ostb); end
    a_stb = 4'b1000;
    tick();
    checks++; if (a_ack !== 4'b1000 || a_exc !== 1'b1) begin errors++; $display("[TB] FAIL viol_recover_ack: got ack=%b exc=%b expected ack=1000 exc=1", a_ack, a_exc); end
    tick();
    a_stb = 4'b0000;
    checks++; if (a_ostb !== 1'b1 || a_out !== 32'h33 || a_ch !== 2'd3) begin errors++; $display("[TB] FAIL viol_recover_word: got stb=%b data=%h ch=%0d expected stb=1 data=33 ch=3", a_ostb, a_out, a_ch); end
    tick();
    checks++; if (a_ostb !== 1'b1 || a_exc !== 1'b1) begin errors++; $display("[TB] FAIL viol_hold: got stb=%b exc=%b expected stb=1 exc=1", a_ostb, a_exc); end
    rst = 1'b0;
    tick();
    checks++; if (a_exc !== 1'b0 || a_ostb !== 1'b0 || a_ack !== 4'b0000 || a_out !== 32'h0) begin errors++; $display("[TB] FAIL viol_reset: got exc=%b stb=%b ack=%b data=%h expected all zero", a_exc, a_ostb, a_ack, a_out); end
    rst = 1'b1;
    tick();
    tick();
    checks++; if (a_ack !== 4'b0000 || a_ostb !== 1'b0) begin errors++; $display("[TB] FAIL viol_post_reset: got ack=%b stb=%b expected 0000/0", a_ack, a_ostb); end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    rst = 1'b1;
    a_stb = '0; a_oack = 1'b0; a_in = '0;
    b_stb = '0; b_oack = 1'b0; b_in = '0;
    c_stb = '0; c_oack = 1'b0; c_in = '0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_fixed_priority();
    test_message_lock();
    test_lock_timeout();
    test_violation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
